// File: rtl/r200_ifq.sv
// r200_ifq: instruction fetch queue with at most one outstanding imem request.
// Optional macro R200_IFQ_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module r200_ifq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instrn,
    output logic [31:0] id_pc_addrout,
    output logic [31:0] id_pcp4,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_count
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];

    logic            issue;
    logic            take_ack;
    logic            bypass_vld;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Request only while the queue has room; the single outstanding slot is free in IDLE.
    assign issue    = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !rst && !redirect;
    assign take_ack = (state_q == WAIT) && imem_ack && !rst && !redirect;

`ifdef R200_IFQ_BYPASS_EN
    assign bypass_vld = take_ack && (count_q == '0);
`else
    assign bypass_vld = 1'b0;
`endif

    assign pop  = (count_q != '0) && id_ready;
    assign push = take_ack && !(bypass_vld && id_ready);

    assign imem_req      = issue;
    assign imem_addr     = fetch_pc_q;
    assign id_valid      = (count_q != '0) || bypass_vld;
    assign id_pc_addrout = bypass_vld ? req_pc_q   : pc_mem_q[rd_ptr_q];
    assign id_instrn     = bypass_vld ? imem_rdata : ins_mem_q[rd_ptr_q];
    assign id_pcp4       = id_pc_addrout + 32'd4;
    assign dbg_state     = state_q;
    assign dbg_count     = 4'(count_q);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                // An ack coinciding with a redirect is simply discarded; only a
                // still-pending response needs the DROP state.
                if (imem_ack)      state_d = IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A response still in flight at reset must be swallowed when it lands.
            if ((state_q == WAIT || state_q == DROP) && !imem_ack) state_q <= DROP;
            else                                                   state_q <= IDLE;
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= NOP;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]  <= req_pc_q;
                ins_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_r200_ifq.sv
// Directed bench for r200_ifq: memory responder, in-order pop scoreboard and hold checks.
module tb_r200_ifq;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instrn;
    logic [31:0] id_pc_addrout;
    logic [31:0] id_pcp4;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_pops   = 0;
    int          n;
    logic        ack_en;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        hold_prev;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;
    logic        seen_top;
    logic        seen_zero;
    logic [31:0] top_pcp4;

    always #5 clk = ~clk;

    r200_ifq #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instrn     (id_instrn),
        .id_pc_addrout (id_pc_addrout),
        .id_pcp4       (id_pcp4),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample this cycle's outputs, then drive the next cycle's ack.
    task automatic step();
        #1;
        if (!rst) begin
            if (id_valid && id_ready) begin
                chk("pop_pc", id_pc_addrout, exp_pc);
                chk("pop_instrn", id_instrn, ~exp_pc);
                chk("pop_pcp4", id_pcp4, exp_pc + 32'd4);
                if (exp_pc == 32'hFFFF_FFFC) begin
                    seen_top = 1'b1;
                    top_pcp4 = id_pcp4;
                end
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            if (hold_prev) begin
                chk("hold_valid", {31'd0, id_valid}, 32'd1);
                chk("hold_pc", id_pc_addrout, prev_pc);
                chk("hold_instrn", id_instrn, prev_ins);
            end
        end
        if (imem_ack) pend = 1'b0;
        if (imem_req) begin
            chk("issue_addr", imem_addr, exp_addr);
            if (imem_addr == 32'd0) seen_zero = 1'b1;
            exp_addr  = exp_addr + 32'd4;
            pend      = 1'b1;
            pend_addr = imem_addr;
        end
        hold_prev = id_valid && !id_ready && !redirect && !rst;
        prev_pc   = id_pc_addrout;
        prev_ins  = id_instrn;
        if (rst) begin
            exp_pc   = RST_PC;
            exp_addr = RST_PC;
        end else if (redirect) begin
            exp_pc   = redirect_pc & 32'hFFFF_FFFC;
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        @(negedge clk);
        imem_ack   = pend && ack_en;
        imem_rdata = imem_ack ? ~pend_addr : 32'hDEAD_BEEF;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b1;
        ack_en      = 1'b1;
        pend        = 1'b0;
        pend_addr   = 32'd0;
        exp_pc      = RST_PC;
        exp_addr    = RST_PC;
        hold_prev   = 1'b0;
        prev_pc     = 32'd0;
        prev_ins    = 32'd0;
        seen_top    = 1'b0;
        seen_zero   = 1'b0;
        top_pcp4    = 32'hFFFF_FFFF;

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instrn", id_instrn, NOP);
        chk("rst_pc", id_pc_addrout, 32'd0);
        chk("rst_pcp4", id_pcp4, 32'd4);
        chk("rst_count", {28'd0, dbg_count}, 32'd0);

        // First fetch after reset, sequential stream with 1-cycle ack
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        step();
        chk("ack_state", {30'd0, dbg_state}, 32'd1);
`ifdef R200_IFQ_BYPASS_EN
        chk("bypass_valid", {31'd0, id_valid}, 32'd1);
        chk("bypass_pc", id_pc_addrout, RST_PC);
        step();
`else
        chk("lat_valid0", {31'd0, id_valid}, 32'd0);
        step();
        chk("lat_valid1", {31'd0, id_valid}, 32'd1);
        chk("lat_pc", id_pc_addrout, RST_PC);
`endif
        repeat (6) step();
        chk("seq_pops", 32'(n_pops >= 3), 32'd1);

        // Decode stall fills the queue, then drains in order
        id_ready = 1'b0;
        repeat (12) step();
        chk("full_count", {28'd0, dbg_count}, 32'd4);
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_valid", {31'd0, id_valid}, 32'd1);
        id_ready = 1'b1;
        n_pops = 0;
        repeat (4) step();
        chk("drain_pops", n_pops, 32'd4);

        // Redirect with a request outstanding: late ack dropped
        ack_en = 1'b0;
        n = 0;
        while (!(pend && !imem_ack) && n < 20) begin step(); n++; end
        chk("drop_setup", 32'(pend && !imem_ack), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        ack_en   = 1'b1;
        chk("drop_state", {30'd0, dbg_state}, 32'd2);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_count", {28'd0, dbg_count}, 32'd0);
        n_pops = 0;
        repeat (8) step();
        chk("flush_pops", 32'(n_pops > 0), 32'd1);

        // Redirect coinciding with ack: no DROP, refetch next cycle
        n = 0;
        while (!imem_ack && n < 20) begin step(); n++; end
        chk("coinc_ack_seen", {31'd0, imem_ack}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        #1;
        chk("coinc_state", {30'd0, dbg_state}, 32'd0);
        chk("coinc_req", {31'd0, imem_req}, 32'd1);
        chk("coinc_addr", imem_addr, 32'h0000_0300);
        chk("coinc_valid", {31'd0, id_valid}, 32'd0);
        repeat (6) step();

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        repeat (14) step();
        chk("wrap_seen_top", {31'd0, seen_top}, 32'd1);
        chk("wrap_pcp4", top_pcp4, 32'd0);
        chk("wrap_issue_zero", {31'd0, seen_zero}, 32'd1);

        // Reset in the middle of WAIT
        ack_en = 1'b0;
        n = 0;
        while (!(pend && !imem_ack) && n < 20) begin step(); n++; end
        chk("rstw_setup", 32'(pend && !imem_ack), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstw_state", {30'd0, dbg_state}, 32'd2);
        chk("rstw_valid", {31'd0, id_valid}, 32'd0);
        chk("rstw_instrn", id_instrn, NOP);
        chk("rstw_pc", id_pc_addrout, 32'd0);
        chk("rstw_req", {31'd0, imem_req}, 32'd0);
        ack_en = 1'b1;
        n_pops = 0;
        step();
        chk("rstw_late_ack", {31'd0, imem_ack}, 32'd1);
        chk("rstw_late_state", {30'd0, dbg_state}, 32'd2);
        step();
        chk("rstw_req2", {31'd0, imem_req}, 32'd1);
        chk("rstw_addr", imem_addr, RST_PC);
        step();
`ifdef R200_IFQ_BYPASS_EN
        chk("rstw_bypass_valid", {31'd0, id_valid}, 32'd1);
        chk("rstw_bypass_pc", id_pc_addrout, RST_PC);
`else
        chk("rstw_ack_valid", {31'd0, id_valid}, 32'd0);
`endif
        repeat (4) step();
        chk("rstw_pops", 32'(n_pops > 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/r200_ifq.md
R200_IFQ -- requirements
Module: r200_ifq

Interface
REQ-001 The block SHALL have one clock and one reset: clock port clk, reset port rst, reset synchronous and active-high.
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and be the PC fetched first after reset.
REQ-003 Parameter DEPTH SHALL default to 4 and be the queue depth in entries (power of two, 2..8).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  32  fetch word address (bits [1:0] always 0).
REQ-008 imem_ack  in  1  response valid, at least one cycle after its accepted request.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-010 redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  32  new fetch PC, sampled when redirect=1.
REQ-012 id_ready  in  1  decode can accept (0 = hazard stall).
REQ-013 id_valid  out  1  id_instrn/id_pc_addrout/id_pcp4 hold a valid instruction.
REQ-014 id_instrn  out  32  instruction to decode.
REQ-015 id_pc_addrout  out  32  PC of id_instrn.
REQ-016 id_pcp4  out  32  id_pc_addrout + 4, modulo 2^32.

Function
REQ-017 The block SHALL keep at most one imem request outstanding; a request is accepted on the cycle imem_req=1.
REQ-018 The FSM SHALL have states IDLE, WAIT, DROP; reset enters IDLE.
REQ-019 IDLE: imem_req=1 when queue entries + outstanding < DEPTH; issue -> WAIT, fetch_pc += 4.
REQ-020 WAIT: on imem_ack, push {fetch-time PC, imem_rdata}; then -> IDLE.
REQ-021 redirect=1 in WAIT without imem_ack SHALL go to DROP; the next imem_ack is discarded, then -> IDLE.
REQ-022 redirect=1 in any state SHALL empty the queue, set fetch_pc=redirect_pc, and force id_valid=0 in the following cycle.
REQ-023 redirect coinciding with imem_ack SHALL discard that response and go to IDLE, not DROP.
REQ-024 Pop SHALL occur on id_valid & id_ready; id outputs present the queue head.
REQ-025 Push and pop in the same cycle SHALL leave the count unchanged; a full queue SHALL never be pushed (guaranteed by REQ-019).
REQ-026 Pointers SHALL wrap modulo DEPTH; fetch_pc SHALL wrap from 32'hFFFF_FFFC to 0.
REQ-027 Queue-to-decode latency without bypass: imem_ack at cycle N -> id_valid at cycle N+1.
REQ-028 id outputs SHALL hold stable while id_valid=1 and id_ready=0.
REQ-029 redirect_pc[1:0] SHALL be ignored (forced to 0).

Reset
REQ-030 With rst=1 at a rising edge: state=IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, id_valid=0, id_instrn=32'h0000_0013 (NOP), id_pc_addrout=0, id_pcp4=4.
REQ-031 rst SHALL override redirect and imem_ack in the same cycle; a response in flight at reset SHALL be discarded (enter DROP if outstanding, else IDLE).
REQ-032 imem_req SHALL first assert in the cycle after rst deasserts, with imem_addr=RESET_PC.

Configuration
REQ-033 Macro R200_IFQ_BYPASS_EN: when defined, an imem_ack arriving with the queue empty and no redirect SHALL drive id outputs combinationally that cycle (id_valid=1, latency 0), skipping the queue if id_ready=1; when undefined, REQ-027 latency of 1 SHALL apply always.

Verification
REQ-034 Reset with RESET_PC=32'h100, imem_ack one cycle after each request, id_ready=1 -> imem_addr 0x100,0x104,0x108; id_pc_addrout follows in order with id_pcp4=PC+4.
REQ-035 id_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 entries buffered, imem_req=0 afterwards, id outputs stable; release -> 4 pops in order, no loss.
REQ-036 redirect=1, redirect_pc=32'h200 while a request is outstanding -> that late ack is dropped, next imem_addr=0x200, first id_pc_addrout after flush=0x200.
REQ-037 redirect and imem_ack in the same cycle -> response discarded, no DROP, imem_addr=redirect_pc next cycle.
REQ-038 fetch_pc at 32'hFFFF_FFFC -> next imem_addr=0, id_pcp4 for that entry=0.
REQ-039 rst asserted mid-WAIT -> late ack discarded, id_valid=0, first post-reset id_pc_addrout=RESET_PC; with R200_IFQ_BYPASS_EN, empty-queue ack gives id_valid=1 in the same cycle.
